riscv_multicycle_ctrl: RTL
==========================

# riscv_multicycle_ctrl

Multi-cycle main control FSM for the single-memory RISC-V core. It sequences fetch, PC increment, execute, memory access and writeback. It drives the 5-bit ALU OpCode and the datapath mux and enable strobes that sit directly upstream of the ALU. The ALU registers its result on every clk edge, so this block holds the ALU op and operand selects stable for as long as the ALU result is being consumed.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  32  current instruction register contents, written by the datapath when ir_write is high.
- zero  in  1  ALU Zero flag (Result == 0).
- mem_ready  in  1  memory access completes this cycle.
- mem_read, mem_write  out  1  memory strobes; held until mem_ready.
- iord  out  1  memory address select: 0 = PC, 1 = ALU Result.
- ir_write  out  1  load instr register from memory read data.
- pc_write  out  1  PC <= ALU Result.
- reg_write  out  1  register file write of rd.
- wb_sel  out  2  writeback source: 0 = ALU Result, 1 = memory data, 2 = PC.
- src_a_sel  out  1  SrcA select: 0 = PC, 1 = rs1.
- src_b_sel  out  1  SrcB select: 0 = rs2, 1 = immediate.
- alu_op  out  5  ALU OpCode: ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, SLT=9, LUI=10, SLTU=11, BGE=12, BGEU=13, ADDPC=14, JBADDRESS=15, BNE=16, BLT=17, BLTU=18; idle=0.
- illegal  out  1  illegal-opcode flag (see Configuration).

## Operation
- States: START, FETCH, PCINC, PCUPD, EXEC, ALUWB, MEMRD, LDWB, MEMWR, BRCMP, BRUPD, JWB, HALT.
- START: all outputs 0. Goes to FETCH on the next clock.
- FETCH: mem_read=1, iord=0. Stays while !mem_ready. On mem_ready: ir_write=1 (Mealy), then go to PCINC.
- PCINC: alu_op=ADDPC, src_a_sel=0. Go to PCUPD.
- PCUPD: pc_write=1, so PC becomes old PC+4. Decode instr[6:0] and go to EXEC.
- EXEC issues the ALU op, then branches by opcode:
  - R 0110011: src_a=1, src_b=0. funct3 000→ADD/SUB (SUB if funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (funct7[5]), 110 OR, 111 AND. Next state ALUWB.
  - I-ALU 0010011: same decode with src_b=1, except funct3 000 is always ADD. Next state ALUWB.
  - LUI 0110111: op LUI, src_b=1. Next state ALUWB.
  - AUIPC 0010111: op JBADDRESS, src_a=0, src_b=1. Next state ALUWB.
  - LOAD 0000011: op ADD, src_a=1, src_b=1. Next state MEMRD.
  - STORE 0100011: op ADD, src_a=1, src_b=1. Next state MEMWR.
  - BRANCH 1100011: src_a=1, src_b=0. funct3 000 SUB, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 are illegal. Next state BRCMP.
  - JAL 1101111: op JBADDRESS, src_a=0, src_b=1. Next state JWB.
  - JALR 1100111: op ADD, src_a=1, src_b=1. Next state JWB.
- ALUWB: reg_write=1, wb_sel=0. Go to FETCH.
- MEMRD and MEMWR:
  - iord=1; mem_read or mem_write respectively.
  - alu_op and selects are held at the EXEC values so the ALU Result stays stable.
  - Both wait for mem_ready. MEMRD then goes to LDWB; MEMWR goes to FETCH.
- LDWB: reg_write=1, wb_sel=1. Go to FETCH.
- BRCMP:
  - Latch taken=zero. Zero=1 means taken for every branch op; this is the ALU encoding contract.
  - Issue JBADDRESS with src_a=0, src_b=1.
  - Go to BRUPD.
- BRUPD: pc_write=taken, alu_op held at JBADDRESS. Go to FETCH.
- JWB: reg_write=1, wb_sel=2 (PC+4), and pc_write=1 in the same cycle. Go to FETCH.

## Timing
- Reset: state=START; all outputs 0; taken=0. Reset asserted mid-access aborts immediately with no strobe completing.
- Latency in cycles, with zero-wait memory:
  - ALU instruction: 5.
  - Load: 6.
  - Store: 5.
  - Branch: 6.
  - JAL/JALR: 5.
- Each mem_ready wait cycle adds one cycle.
- ALU Result is valid the cycle after alu_op is presented. Consumers (pc_write, reg_write, iord) only act in that following state.
- mem_ready while no strobe is asserted is ignored.

## Configuration
- RISCV_CTRL_ILLEGAL_TRAP_EN defined:
  - An unsupported opcode or branch funct3 in PCUPD goes to HALT.
  - HALT: illegal=1, all other outputs 0, no exit except rst.
- Not defined:
  - Illegal instructions act as NOP: PCUPD goes to FETCH.
  - illegal is tied 0.

## Test plan
- ADD x3=x1+x2 (instr 0x002081B3), mem_ready=1 -> alu_op=1 in EXEC, src_a=1, src_b=0. reg_write=1, wb_sel=0 exactly 5 cycles after FETCH entry.
- LW (0x0000A183) with mem_ready low for 3 cycles in MEMRD -> mem_read and iord held with alu_op=1 stable. reg_write, wb_sel=1 one cycle after mem_ready.
- BEQ (funct3 000), zero=1 in BRCMP -> pc_write=1 in BRUPD. Repeat with zero=0 -> pc_write stays 0.
- JAL (0x008000EF) -> alu_op=15 in EXEC. JWB has reg_write=1, wb_sel=2 and pc_write=1 in the same cycle.
- Opcode 0x7F: with the macro -> HALT, illegal=1 persists until rst. Without the macro -> returns to FETCH, no writes.
- rst pulse during MEMWR wait -> mem_write drops asynchronously, state START, then FETCH next cycle.

Source files
------------

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle main control FSM for the single-memory RISC-V core.
// Optional RISCV_CTRL_ILLEGAL_TRAP_EN: trap unsupported instructions in HALT with illegal=1.
module riscv_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        src_a_sel,
  output logic        src_b_sel,
  output logic [4:0]  alu_op,
  output logic        illegal
);

  localparam logic [4:0] AluIdle = 5'd0,  AluAdd  = 5'd1,  AluSub  = 5'd2,  AluAnd    = 5'd3;
  localparam logic [4:0] AluOr   = 5'd4,  AluXor  = 5'd5,  AluSll  = 5'd6,  AluSrl    = 5'd7;
  localparam logic [4:0] AluSra  = 5'd8,  AluSlt  = 5'd9,  AluLui  = 5'd10, AluSltu   = 5'd11;
  localparam logic [4:0] AluBge  = 5'd12, AluBgeu = 5'd13, AluAddPc = 5'd14, AluJbAddr = 5'd15;
  localparam logic [4:0] AluBne  = 5'd16, AluBlt  = 5'd17, AluBltu = 5'd18;

  localparam logic [6:0] OpR      = 7'b0110011, OpImm   = 7'b0010011, OpLui  = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111, OpLoad  = 7'b0000011, OpStore = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011, OpJal   = 7'b1101111, OpJalr = 7'b1100111;

  typedef enum logic [3:0] {
    StStart, StFetch, StPcInc, StPcUpd, StExec, StAluWb, StMemRd,
    StLdWb, StMemWr, StBrCmp, StBrUpd, StJWb, StHalt
  } state_e;

  state_e     state_q, state_d;
  logic       taken_q, taken_d;
  logic       mem_read_q, mem_read_d, mem_write_q, mem_write_d, iord_q, iord_d;
  logic       pc_write_q, pc_write_d, reg_write_q, reg_write_d;
  logic [1:0] wb_sel_q, wb_sel_d;
  logic       src_a_q, src_a_d, src_b_q, src_b_d;
  logic [4:0] alu_op_q, alu_op_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       unused_instr;
  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7_b5    = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  logic [4:0] arith_op, dec_op;
  logic       dec_src_a, dec_src_b, dec_illegal;
  state_e     dec_next;

  always_comb begin
    arith_op = AluAdd;
    case (funct3)
      3'b000:  arith_op = (opcode == OpR && funct7_b5) ? AluSub : AluAdd;
      3'b001:  arith_op = AluSll;
      3'b010:  arith_op = AluSlt;
      3'b011:  arith_op = AluSltu;
      3'b100:  arith_op = AluXor;
      3'b101:  arith_op = funct7_b5 ? AluSra : AluSrl;
      3'b110:  arith_op = AluOr;
      default: arith_op = AluAnd;
    endcase
  end

  always_comb begin
    dec_op      = AluAdd;
    dec_src_a   = 1'b1;
    dec_src_b   = 1'b1;
    dec_illegal = 1'b0;
    dec_next    = StFetch;
    case (opcode)
      OpR:     begin dec_op = arith_op; dec_src_b = 1'b0; dec_next = StAluWb; end
      OpImm:   begin dec_op = arith_op; dec_next = StAluWb; end
      OpLui:   begin dec_op = AluLui; dec_next = StAluWb; end
      OpAuipc: begin dec_op = AluJbAddr; dec_src_a = 1'b0; dec_next = StAluWb; end
      OpLoad:  dec_next = StMemRd;
      OpStore: dec_next = StMemWr;
      OpBranch: begin
        dec_src_b = 1'b0;
        dec_next  = StBrCmp;
        case (funct3)
          3'b000:  dec_op = AluSub;
          3'b001:  dec_op = AluBne;
          3'b100:  dec_op = AluBlt;
          3'b101:  dec_op = AluBge;
          3'b110:  dec_op = AluBltu;
          3'b111:  dec_op = AluBgeu;
          default: begin dec_op = AluIdle; dec_illegal = 1'b1; end
        endcase
      end
      OpJal:   begin dec_op = AluJbAddr; dec_src_a = 1'b0; dec_next = StJWb; end
      OpJalr:  dec_next = StJWb;
      default: begin dec_op = AluIdle; dec_illegal = 1'b1; end
    endcase
  end

`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Outputs are registered from the next state so they are glitch-free in each state.
  always_comb begin
    state_d     = state_q;
    taken_d     = taken_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    iord_d      = 1'b0;
    pc_write_d  = 1'b0;
    reg_write_d = 1'b0;
    wb_sel_d    = 2'd0;
    src_a_d     = 1'b0;
    src_b_d     = 1'b0;
    alu_op_d    = AluIdle;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    illegal_d   = 1'b0;
`endif
    case (state_q)
      StStart: state_d = StFetch;
      StFetch: if (mem_ready) state_d = StPcInc;
      StPcInc: state_d = StPcUpd;
      StPcUpd: begin
        if (!dec_illegal) state_d = StExec;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
        else              state_d = StHalt;
`else
        else              state_d = StFetch;
`endif
      end
      StExec:  state_d = dec_next;
      StMemRd: if (mem_ready) state_d = StLdWb;
      StMemWr: if (mem_ready) state_d = StFetch;
      StBrCmp: begin state_d = StBrUpd; taken_d = zero; end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase

    case (state_d)
      StFetch: mem_read_d = 1'b1;
      StPcInc: alu_op_d = AluAddPc;
      StPcUpd: pc_write_d = 1'b1;
      StExec:  begin alu_op_d = dec_op; src_a_d = dec_src_a; src_b_d = dec_src_b; end
      StAluWb: reg_write_d = 1'b1;
      // Keep the address computation alive while memory stalls.
      StMemRd: begin
        mem_read_d = 1'b1; iord_d = 1'b1;
        alu_op_d = alu_op_q; src_a_d = src_a_q; src_b_d = src_b_q;
      end
      StMemWr: begin
        mem_write_d = 1'b1; iord_d = 1'b1;
        alu_op_d = alu_op_q; src_a_d = src_a_q; src_b_d = src_b_q;
      end
      StLdWb:  begin reg_write_d = 1'b1; wb_sel_d = 2'd1; end
      StBrCmp: begin alu_op_d = AluJbAddr; src_b_d = 1'b1; end
      StBrUpd: begin
        pc_write_d = taken_d;
        alu_op_d = alu_op_q; src_a_d = src_a_q; src_b_d = src_b_q;
      end
      StJWb:   begin reg_write_d = 1'b1; wb_sel_d = 2'd2; pc_write_d = 1'b1; end
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
      StHalt:  illegal_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StStart;
      taken_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      iord_q      <= 1'b0;
      pc_write_q  <= 1'b0;
      reg_write_q <= 1'b0;
      wb_sel_q    <= 2'd0;
      src_a_q     <= 1'b0;
      src_b_q     <= 1'b0;
      alu_op_q    <= AluIdle;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      taken_q     <= taken_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      iord_q      <= iord_d;
      pc_write_q  <= pc_write_d;
      reg_write_q <= reg_write_d;
      wb_sel_q    <= wb_sel_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      alu_op_q    <= alu_op_d;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign iord      = iord_q;
  assign pc_write  = pc_write_q;
  assign reg_write = reg_write_q;
  assign wb_sel    = wb_sel_q;
  assign src_a_sel = src_a_q;
  assign src_b_sel = src_b_q;
  assign alu_op    = alu_op_q;
  // Instruction-register load completes in the same cycle memory answers.
  assign ir_write  = (state_q == StFetch) && mem_ready;

endmodule
